// File: rtl/rca_port_config_table_pkg.sv
// Shared configuration for the RCA port configuration table: default sizes,
// config request record and the config FSM state encoding.
package rca_config;

    localparam int NUM_RCAS        = 4;
    localparam int NUM_READ_PORTS  = 5;
    localparam int NUM_WRITE_PORTS = 5;
    localparam int MAX_INFLIGHT    = 4;

    // rca_id sized for the full funct7 field so the record is independent of NUM_RCAS
    typedef struct packed {
        logic [6:0] rca_id;
        logic       is_dest;
        logic [2:0] port;
        logic [4:0] arch_reg;
    } cfg_req_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } cfg_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_port_config_table_counter.sv
// Per-RCA in-flight use-instruction counter; simultaneous issue and retire
// cancel, and a retire with nothing outstanding is dropped.
module rca_inflight_counter #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_eff;

    always_comb begin
        dec_eff = dec_i && (cnt_q != '0);
        cnt_d   = cnt_q;
        if (inc_i && !dec_eff && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_eff && !inc_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/rca_port_config_table.sv
// Per-RCA source/destination port-to-register map with in-flight tracking.
// Optional per-port valid mask storage is enabled by RCA_CFG_VALID_MASK_EN.
module rca_port_config_table #(
    parameter int  NUM_RCAS        = rca_config::NUM_RCAS,
    parameter int  NUM_READ_PORTS  = rca_config::NUM_READ_PORTS,
    parameter int  NUM_WRITE_PORTS = rca_config::NUM_WRITE_PORTS,
    parameter int  MAX_INFLIGHT    = rca_config::MAX_INFLIGHT,
    localparam int RCA_ID_W        = rca_config::id_width(NUM_RCAS),
    localparam int CNT_W           = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [RCA_ID_W-1:0]          cfg_rca_id,
    input  logic                         cfg_is_dest,
    input  logic [2:0]                   cfg_port,
    input  logic [4:0]                   cfg_reg,
    output logic                         cfg_err,
    input  logic                         issue_valid,
    input  logic [RCA_ID_W-1:0]          issue_rca_id,
    output logic                         issue_ready,
    input  logic                         done_valid,
    input  logic [RCA_ID_W-1:0]          done_rca_id,
    input  logic [RCA_ID_W-1:0]          lookup_rca_id,
    output logic [NUM_READ_PORTS*5-1:0]  lookup_src_regs,
    output logic [NUM_WRITE_PORTS*5-1:0] lookup_dst_regs,
    output logic [NUM_READ_PORTS-1:0]    lookup_src_vld,
    output logic [NUM_WRITE_PORTS-1:0]   lookup_dst_vld
);

    // Tables are padded to a power of two so any id value indexes safely.
    localparam int               RCA_SLOTS = 1 << RCA_ID_W;
    localparam logic [3:0]       RD_PORTS  = 4'(NUM_READ_PORTS);
    localparam logic [3:0]       WR_PORTS  = 4'(NUM_WRITE_PORTS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_INFLIGHT);

    rca_config::cfg_state_e state_q, state_d;
    logic [RCA_ID_W-1:0]    drain_id_q, drain_id_d;
    logic [CNT_W-1:0]       cnt [RCA_SLOTS];
    logic                   port_legal;
    logic                   tab_we;
    logic                   issue_fire;

    logic [4:0] src_tab_q [RCA_SLOTS][NUM_READ_PORTS];
    logic [4:0] src_tab_d [RCA_SLOTS][NUM_READ_PORTS];
    logic [4:0] dst_tab_q [RCA_SLOTS][NUM_WRITE_PORTS];
    logic [4:0] dst_tab_d [RCA_SLOTS][NUM_WRITE_PORTS];

    logic [NUM_READ_PORTS*5-1:0]  lookup_src_regs_q, lookup_src_regs_d;
    logic [NUM_WRITE_PORTS*5-1:0] lookup_dst_regs_q, lookup_dst_regs_d;
    logic [NUM_READ_PORTS-1:0]    lookup_src_vld_q, lookup_src_vld_d;
    logic [NUM_WRITE_PORTS-1:0]   lookup_dst_vld_q, lookup_dst_vld_d;

    assign issue_ready = (cnt[issue_rca_id] != CNT_MAX) &&
                         !((state_q == rca_config::ST_DRAIN) && (drain_id_q == issue_rca_id));
    assign issue_fire  = issue_valid && issue_ready;

    generate
        for (genvar gi = 0; gi < RCA_SLOTS; gi++) begin : g_cnt
            if (gi < NUM_RCAS) begin : g_real
                rca_inflight_counter #(
                    .MAX_INFLIGHT (MAX_INFLIGHT),
                    .CNT_W        (CNT_W)
                ) u_cnt (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .inc_i (issue_fire && (issue_rca_id == RCA_ID_W'(gi))),
                    .dec_i (done_valid && (done_rca_id == RCA_ID_W'(gi))),
                    .cnt_o (cnt[gi])
                );
            end else begin : g_pad
                assign cnt[gi] = '0;
            end
        end
    endgenerate

    // A legal request against a busy RCA parks in DRAIN until its work retires.
    always_comb begin
        state_d    = state_q;
        drain_id_d = drain_id_q;
        cfg_ready  = 1'b0;
        cfg_err    = 1'b0;
        tab_we     = 1'b0;
        port_legal = cfg_is_dest ? ({1'b0, cfg_port} < WR_PORTS)
                                 : ({1'b0, cfg_port} < RD_PORTS);
        unique case (state_q)
            rca_config::ST_IDLE: begin
                if (cfg_valid) begin
                    if (!port_legal) begin
                        cfg_ready = 1'b1;
                        cfg_err   = 1'b1;
                    end else if (cnt[cfg_rca_id] == '0) begin
                        cfg_ready = 1'b1;
                        tab_we    = 1'b1;
                    end else begin
                        state_d    = rca_config::ST_DRAIN;
                        drain_id_d = cfg_rca_id;
                    end
                end
            end
            rca_config::ST_DRAIN: begin
                if (cnt[drain_id_q] == '0) begin
                    state_d = rca_config::ST_IDLE;
                end
            end
            default: state_d = rca_config::ST_IDLE;
        endcase
        if (!rst_n) begin
            cfg_ready = 1'b0;
            cfg_err   = 1'b0;
            tab_we    = 1'b0;
        end
    end

    always_comb begin
        src_tab_d = src_tab_q;
        dst_tab_d = dst_tab_q;
        if (tab_we && !cfg_is_dest) src_tab_d[cfg_rca_id][cfg_port] = cfg_reg;
        if (tab_we && cfg_is_dest)  dst_tab_d[cfg_rca_id][cfg_port] = cfg_reg;
        lookup_src_regs_d = '0;
        lookup_dst_regs_d = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++)  lookup_src_regs_d[p*5 +: 5] = src_tab_d[lookup_rca_id][p];
        for (int p = 0; p < NUM_WRITE_PORTS; p++) lookup_dst_regs_d[p*5 +: 5] = dst_tab_d[lookup_rca_id][p];
    end

`ifdef RCA_CFG_VALID_MASK_EN
    logic [NUM_READ_PORTS-1:0]  src_vld_q [RCA_SLOTS];
    logic [NUM_READ_PORTS-1:0]  src_vld_d [RCA_SLOTS];
    logic [NUM_WRITE_PORTS-1:0] dst_vld_q [RCA_SLOTS];
    logic [NUM_WRITE_PORTS-1:0] dst_vld_d [RCA_SLOTS];

    always_comb begin
        src_vld_d = src_vld_q;
        dst_vld_d = dst_vld_q;
        if (tab_we && !cfg_is_dest) src_vld_d[cfg_rca_id][cfg_port] = 1'b1;
        if (tab_we && cfg_is_dest)  dst_vld_d[cfg_rca_id][cfg_port] = 1'b1;
        lookup_src_vld_d = src_vld_d[lookup_rca_id];
        lookup_dst_vld_d = dst_vld_d[lookup_rca_id];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < RCA_SLOTS; r++) begin
                src_vld_q[r] <= '0;
                dst_vld_q[r] <= '0;
            end
        end else begin
            src_vld_q <= src_vld_d;
            dst_vld_q <= dst_vld_d;
        end
    end
`else
    // Without mask storage every port reads as configured.
    assign lookup_src_vld_d = '1;
    assign lookup_dst_vld_d = '1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= rca_config::ST_IDLE;
            drain_id_q        <= '0;
            lookup_src_regs_q <= '0;
            lookup_dst_regs_q <= '0;
            lookup_src_vld_q  <= '0;
            lookup_dst_vld_q  <= '0;
            for (int r = 0; r < RCA_SLOTS; r++) begin
                for (int p = 0; p < NUM_READ_PORTS; p++)  src_tab_q[r][p] <= '0;
                for (int p = 0; p < NUM_WRITE_PORTS; p++) dst_tab_q[r][p] <= '0;
            end
        end else begin
            state_q           <= state_d;
            drain_id_q        <= drain_id_d;
            lookup_src_regs_q <= lookup_src_regs_d;
            lookup_dst_regs_q <= lookup_dst_regs_d;
            lookup_src_vld_q  <= lookup_src_vld_d;
            lookup_dst_vld_q  <= lookup_dst_vld_d;
            src_tab_q         <= src_tab_d;
            dst_tab_q         <= dst_tab_d;
        end
    end

    assign lookup_src_regs = lookup_src_regs_q;
    assign lookup_dst_regs = lookup_dst_regs_q;
    assign lookup_src_vld  = lookup_src_vld_q;
    assign lookup_dst_vld  = lookup_dst_vld_q;

endmodule

// File: doc/rca_port_config_table.md
RCA_PORT_CONFIG_TABLE -- requirements
Module: rca_port_config_table

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
 - NUM_RCAS, 4, number of accelerators; RCA_ID_W = max(1, clog2(NUM_RCAS)).
 - NUM_READ_PORTS, 5, source ports per RCA (max 8).
 - NUM_WRITE_PORTS, 5, destination ports per RCA (max 8).
 - MAX_INFLIGHT, 4, outstanding use instructions per RCA; CNT_W = clog2(MAX_INFLIGHT+1).
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
 - clk, in, 1, single clock.
 - rst_n, in, 1, synchronous active-low reset.
 - cfg_valid, in, 1, config request present.
 - cfg_ready, out, 1, config request accepted this cycle.
 - cfg_rca_id, in, RCA_ID_W, target RCA (funct7).
 - cfg_is_dest, in, 1, 1 = destination port, 0 = source port (rs1[3]).
 - cfg_port, in, 3, port index (rs1[2:0]).
 - cfg_reg, in, 5, architectural register (rs2[4:0]).
 - cfg_err, out, 1, one-cycle pulse: illegal port index.
 - issue_valid, in, 1, use instruction issuing.
 - issue_rca_id, in, RCA_ID_W, RCA targeted by the issue.
 - issue_ready, out, 1, issue permitted.
 - done_valid, in, 1, one use instruction retired.
 - done_rca_id, in, RCA_ID_W, RCA that retired it.
 - lookup_rca_id, in, RCA_ID_W, RCA to read.
 - lookup_src_regs, out, NUM_READ_PORTS*5, source register map (port 0 in LSBs).
 - lookup_dst_regs, out, NUM_WRITE_PORTS*5, destination register map.
 - lookup_src_vld, out, NUM_READ_PORTS, configured-port mask.
 - lookup_dst_vld, out, NUM_WRITE_PORTS, configured-port mask.

Function
REQ-003 Lookup outputs SHALL be registered: they reflect table[lookup_rca_id] as sampled one cycle earlier, including any write committed in that same earlier cycle (write-first).
REQ-004 Each RCA SHALL own an in-flight counter: it increments on issue_valid&&issue_ready and decrements on done_valid.
REQ-005 When an issue and a done for the same RCA occur in the same cycle, that counter SHALL remain unchanged.
REQ-006 A done_valid for an RCA whose counter is 0 SHALL be ignored.
REQ-007 issue_ready SHALL be 0 when the counter of issue_rca_id equals MAX_INFLIGHT, or when the FSM is in DRAIN with drain_id == issue_rca_id.
REQ-008 The FSM SHALL have two states, IDLE and DRAIN.
REQ-009 In IDLE, when cfg_valid is high and the port is illegal (cfg_port >= NUM_READ_PORTS for a source, or >= NUM_WRITE_PORTS for a destination), the module SHALL assert cfg_ready and cfg_err for 1 cycle and leave the table unchanged.
REQ-010 In IDLE, when cfg_valid is high, the port is legal and counter[cfg_rca_id] == 0, the module SHALL assert cfg_ready, write cfg_reg into the entry, and set the valid bit.
REQ-011 In IDLE, when cfg_valid is high, the port is legal and counter[cfg_rca_id] > 0, the module SHALL keep cfg_ready low, latch drain_id = cfg_rca_id, and move to DRAIN.
REQ-012 In DRAIN, cfg_ready SHALL stay 0; when counter[drain_id] == 0 the FSM SHALL return to IDLE, and the request is accepted there.
REQ-013 The requester SHALL hold all cfg_* inputs stable from cfg_valid high until cfg_ready; the module need not check this.
REQ-014 cfg_ready SHALL be combinational from state, counters and cfg_* inputs, and SHALL NOT depend on issue_valid.

Reset
REQ-015 While rst_n is low at a clk edge, the module SHALL clear all counters, all table entries (to register 0) and all valid bits, set the FSM to IDLE, and drive cfg_ready, cfg_err and all lookup outputs to 0.
REQ-016 After reset deasserts, issue_ready SHALL be 1.
REQ-017 A reset that occurs while in DRAIN SHALL discard the pending request.

Configuration
REQ-018 With RCA_CFG_VALID_MASK_EN defined, the module SHALL maintain the per-port valid bits described above.
REQ-019 Without RCA_CFG_VALID_MASK_EN, the module SHALL have no valid storage and SHALL drive lookup_src_vld and lookup_dst_vld as all-ones (all-zero during reset).

Structure
REQ-020 The shared package rca_config SHALL hold NUM_RCAS, NUM_READ_PORTS, NUM_WRITE_PORTS, MAX_INFLIGHT, the cfg request struct {rca_id, is_dest, port, reg} and the FSM state enum.
REQ-021 The per-RCA counter SHALL be implemented as one sub-module, rca_inflight_counter, instantiated NUM_RCAS times.

Verification
REQ-022 Reset, then configure RCA 2 src port 3 to x17 with no work in flight -> cfg_ready in the same cycle; with lookup_rca_id=2, the next cycle shows src_regs[3]=17 and src_vld[3]=1.
REQ-023 Issue 2 instructions to RCA 1, then configure RCA 1 -> cfg_ready low and issue_ready low for RCA 1 (RCA 0 still ready); after 2 dones, the FSM returns to IDLE and cfg_ready asserts the cycle after.
REQ-024 Configure a destination port with cfg_port=6 while NUM_WRITE_PORTS=5 -> cfg_ready=1 and cfg_err=1 for 1 cycle; table unchanged.
REQ-025 Issue and done for RCA 3 in the same cycle with counter=1 -> counter stays 1; issue 4 instructions to RCA 0 -> issue_ready=0 for RCA 0.
REQ-026 Assert rst_n low during DRAIN -> FSM in IDLE, all counters 0, all lookup outputs 0 the next cycle.
REQ-027 Build without RCA_CFG_VALID_MASK_EN -> vld outputs read all-ones after reset.
